// File: rtl/port_frame_fifo.sv
// port_frame_fifo: store-and-forward frame FIFO for one egress lane.
// Frames are written as tagged 32-bit words and become visible to the reader
// only once their end word has been committed. A delete or an overflow rolls
// the write pointer back to the last commit point, so partial frames vanish.
module port_frame_fifo #(
    parameter int pDATA_WIDTH = 8,
    parameter int pPORT_WIDTH = 4,
    parameter int pDEPTH      = 256
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic [4*pDATA_WIDTH-1:0]        i_wr_data,
    input  logic                            i_wr_stb,
    input  logic [1:0]                      i_wr_info,
    input  logic [$clog2(pPORT_WIDTH)-1:0]  i_wr_extra,
    input  logic                            i_wr_delete,
    output logic [4*pDATA_WIDTH-1:0]        o_rd_data,
    output logic                            o_rd_valid,
    output logic                            o_rd_sof,
    output logic                            o_rd_eof,
    output logic [$clog2(pPORT_WIDTH)-1:0]  o_rd_extra,
    input  logic                            i_rd_ready,
    output logic [$clog2(pDEPTH):0]         o_frames,
    output logic                            o_full,
    output logic                            o_overflow,
    output logic [15:0]                     o_drop_cnt
);
    localparam int W  = 4*pDATA_WIDTH;
    localparam int E  = $clog2(pPORT_WIDTH);
    localparam int P  = $clog2(pDEPTH) + 1;
    localparam int EW = W + 2 + E;
    localparam logic [P-1:0] PTR_ONE = {{(P-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_DROP} state_t;

    state_t          state_reg;
    logic [P-1:0]    wr_ptr_reg;
    logic [P-1:0]    commit_ptr_reg;
    logic [P-1:0]    rd_ptr_reg;
    logic [P-1:0]    frames_reg;
    logic            overflow_reg;
    logic [15:0]     drop_cnt_reg;

    // Storage and its registered read port (first pipeline stage)
    logic [EW-1:0]   mem [pDEPTH];
    logic [EW-1:0]   mem_q;
    logic            mem_q_valid_reg;

    // Output register (second pipeline stage)
    logic [W-1:0]    rd_data_reg;
    logic            rd_sof_reg;
    logic            rd_eof_reg;
    logic [E-1:0]    rd_extra_reg;
    logic            rd_valid_reg;

    logic            full;
    logic            stb_ok;
    logic            wr_take;
    logic            wr_overflow;
    logic            wr_commit;
    logic [P-1:0]    wr_base;
    logic [P-1:0]    wr_next_ptr;
    logic [E-1:0]    extra_masked;
    logic [EW-1:0]   wr_entry;
    logic            a_load;
    logic            b_load;
    logic            rd_accept;

    // Full when the pointers share low bits but sit on opposite wraps
    assign full   = (wr_ptr_reg[P-1] != rd_ptr_reg[P-1]) &&
                    (wr_ptr_reg[P-2:0] == rd_ptr_reg[P-2:0]);
    assign stb_ok = i_wr_stb && !i_wr_delete;

    // Padding count only means something on an end word; store 0 otherwise
    genvar gi;
    generate
        for (gi = 0; gi < E; gi++) begin : g_extra_mask
            assign extra_masked[gi] = i_wr_extra[gi] & i_wr_info[1];
        end
    endgenerate

    assign wr_entry = {i_wr_info[0], i_wr_info[1], extra_masked, i_wr_data};

    // Write-side decode: decide whether this strobe is stored, dropped or ignored
    always_comb begin
        wr_take     = 1'b0;
        wr_overflow = 1'b0;
        wr_base     = wr_ptr_reg;
        case (state_reg)
            ST_IDLE: begin
                wr_base = commit_ptr_reg;
                if (stb_ok && i_wr_info[0]) begin
                    if (full) wr_overflow = 1'b1;
                    else      wr_take     = 1'b1;
                end
            end
            ST_RECV: begin
                // A new start word mid-frame restarts from the commit point
                if (i_wr_info[0]) wr_base = commit_ptr_reg;
                if (stb_ok) begin
                    if (full) wr_overflow = 1'b1;
                    else      wr_take     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign wr_next_ptr = wr_base + PTR_ONE;
    assign wr_commit   = wr_take && i_wr_info[1];

    // Write FSM: pointers, commit, overflow pulse and drop counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= ST_IDLE;
            wr_ptr_reg     <= '0;
            commit_ptr_reg <= '0;
            overflow_reg   <= 1'b0;
            drop_cnt_reg   <= '0;
        end else begin
            overflow_reg <= 1'b0;
            if (i_wr_delete) begin
                wr_ptr_reg <= commit_ptr_reg;
                state_reg  <= ST_IDLE;
            end else if (wr_overflow) begin
                wr_ptr_reg   <= commit_ptr_reg;
                overflow_reg <= 1'b1;
                if (drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 16'd1;
                state_reg    <= i_wr_info[1] ? ST_IDLE : ST_DROP;
            end else if (wr_take) begin
                wr_ptr_reg <= wr_next_ptr;
                if (wr_commit) begin
                    commit_ptr_reg <= wr_next_ptr;
                    state_reg      <= ST_IDLE;
                end else begin
                    state_reg      <= ST_RECV;
                end
            end else if (state_reg == ST_DROP && i_wr_stb && i_wr_info[1]) begin
                state_reg <= ST_IDLE;
            end
        end
    end

    // Read pipeline handshakes: stage A refills whenever stage B can take its word
    assign rd_accept = rd_valid_reg && i_rd_ready;
    assign b_load    = mem_q_valid_reg && (!rd_valid_reg || i_rd_ready);
    assign a_load    = (rd_ptr_reg != commit_ptr_reg) && (!mem_q_valid_reg || b_load);

    // Block RAM: one write port, one enabled registered read port
    always_ff @(posedge i_clk) begin
        if (wr_take) mem[wr_base[P-2:0]] <= wr_entry;
        if (a_load)  mem_q <= mem[rd_ptr_reg[P-2:0]];
    end

    // Read pointer and stage-A occupancy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr_reg      <= '0;
            mem_q_valid_reg <= 1'b0;
        end else begin
            if (a_load) begin
                rd_ptr_reg      <= rd_ptr_reg + PTR_ONE;
                mem_q_valid_reg <= 1'b1;
            end else if (b_load) begin
                mem_q_valid_reg <= 1'b0;
            end
        end
    end

    // Output register: load on a free slot, hold while stalled, clear when drained
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_data_reg  <= '0;
            rd_sof_reg   <= 1'b0;
            rd_eof_reg   <= 1'b0;
            rd_extra_reg <= '0;
            rd_valid_reg <= 1'b0;
        end else if (b_load) begin
            rd_data_reg  <= mem_q[W-1:0];
            rd_extra_reg <= mem_q[W+E-1:W];
            rd_eof_reg   <= mem_q[W+E];
            rd_sof_reg   <= mem_q[W+E+1];
            rd_valid_reg <= 1'b1;
        end else if (rd_accept) begin
            rd_data_reg  <= '0;
            rd_sof_reg   <= 1'b0;
            rd_eof_reg   <= 1'b0;
            rd_extra_reg <= '0;
            rd_valid_reg <= 1'b0;
        end
    end

    // Frame count: +1 per commit, -1 per accepted end word
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frames_reg <= '0;
        end else if (wr_commit && !(rd_accept && rd_eof_reg)) begin
            frames_reg <= frames_reg + PTR_ONE;
        end else if (!wr_commit && rd_accept && rd_eof_reg) begin
            frames_reg <= frames_reg - PTR_ONE;
        end
    end

    assign o_rd_data  = rd_data_reg;
    assign o_rd_valid = rd_valid_reg;
    assign o_rd_sof   = rd_sof_reg;
    assign o_rd_eof   = rd_eof_reg;
    assign o_rd_extra = rd_extra_reg;
    assign o_frames   = frames_reg;
    assign o_full     = full;
    assign o_overflow = overflow_reg;
    assign o_drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_port_frame_fifo.sv
// tb_port_frame_fifo: directed checks of frame commit, delete, overflow,
// restart, back-pressure and asynchronous reset on a 16-entry instance.
module tb_port_frame_fifo;
    localparam int DW    = 8;
    localparam int PW    = 4;
    localparam int DEPTH = 16;
    localparam int W     = 4*DW;
    localparam int E     = 2;
    localparam int P     = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic          wr_stb = 1'b0;
    logic [1:0]    wr_info = '0;
    logic [E-1:0]  wr_extra = '0;
    logic          wr_delete = 1'b0;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic          rd_sof;
    logic          rd_eof;
    logic [E-1:0]  rd_extra;
    logic          rd_ready = 1'b0;
    logic [P-1:0]  frames;
    logic          full;
    logic          overflow;
    logic [15:0]   drop_cnt;

    always #5 clk = ~clk;

    port_frame_fifo #(
        .pDATA_WIDTH(DW),
        .pPORT_WIDTH(PW),
        .pDEPTH(DEPTH)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_wr_data(wr_data),
        .i_wr_stb(wr_stb),
        .i_wr_info(wr_info),
        .i_wr_extra(wr_extra),
        .i_wr_delete(wr_delete),
        .o_rd_data(rd_data),
        .o_rd_valid(rd_valid),
        .o_rd_sof(rd_sof),
        .o_rd_eof(rd_eof),
        .o_rd_extra(rd_extra),
        .i_rd_ready(rd_ready),
        .o_frames(frames),
        .o_full(full),
        .o_overflow(overflow),
        .o_drop_cnt(drop_cnt)
    );

    int n_total = 0;
    int n_pass  = 0;
    logic [35:0] got_q[$];
    logic [35:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] info, input logic [31:0] data, input logic [1:0] extra);
        wr_stb   = 1'b1;
        wr_info  = info;
        wr_data  = data;
        wr_extra = extra;
        tick();
        wr_stb   = 1'b0;
        wr_info  = 2'b00;
        wr_extra = '0;
    endtask

    function automatic logic [35:0] mk(input logic sof, input logic eof,
                                       input logic [1:0] x, input logic [31:0] d);
        return {sof, eof, x, d};
    endfunction

    function automatic logic [35:0] head();
        return {rd_sof, rd_eof, rd_extra, rd_data};
    endfunction

    // Hold ready high and record every head word seen before the edge that accepts it
    task automatic drain(input int max_cycles);
        got_q.delete();
        rd_ready = 1'b1;
        for (int i = 0; i < max_cycles; i++) begin
            if (rd_valid) got_q.push_back(head());
            tick();
        end
        rd_ready = 1'b0;
    endtask

    task automatic compare(input string tag);
        $display("frame %s: %0d words read, %0d expected", tag, got_q.size(), exp_q.size());
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [36:0] snap;
        logic [1:0]  info;

        // ---- reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(rd_valid), 64'd0);
        check("rst_frames", 64'(frames), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_data", 64'(rd_data), 64'd0);
        rst_n = 1'b1;
        tick();

        // ---- 4-word frame, middle-word extra must be stored as 0
        wr(2'b01, 32'hA000_0000, 2'd0);
        check("f4_frames_open", 64'(frames), 64'd0);
        wr(2'b00, 32'hA000_0001, 2'd1);
        wr(2'b00, 32'hA000_0002, 2'd0);
        wr(2'b10, 32'hA000_0003, 2'd2);
        check("f4_frames_commit", 64'(frames), 64'd1);
        drain(12);
        exp_q.push_back(mk(1'b1, 1'b0, 2'd0, 32'hA000_0000));
        exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 32'hA000_0001));
        exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 32'hA000_0002));
        exp_q.push_back(mk(1'b0, 1'b1, 2'd2, 32'hA000_0003));
        compare("f4");
        check("f4_frames_done", 64'(frames), 64'd0);

        // ---- single-word frame, latency of two edges after the commit edge
        wr(2'b11, 32'hB000_0000, 2'd3);
        check("sw_valid_k", 64'(rd_valid), 64'd0);
        tick();
        check("sw_valid_k1", 64'(rd_valid), 64'd0);
        tick();
        check("sw_valid_k2", 64'(rd_valid), 64'd1);
        check("sw_head", 64'(head()), 64'(mk(1'b1, 1'b1, 2'd3, 32'hB000_0000)));
        check("sw_frames", 64'(frames), 64'd1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("sw_valid_after", 64'(rd_valid), 64'd0);
        check("sw_frames_after", 64'(frames), 64'd0);

        // ---- delete after 3 words; delete also beats a simultaneous end word
        wr(2'b01, 32'hD000_0000, 2'd0);
        wr(2'b00, 32'hD000_0001, 2'd0);
        wr(2'b00, 32'hD000_0002, 2'd0);
        wr_delete = 1'b1;
        wr(2'b10, 32'hD000_0003, 2'd1);
        wr_delete = 1'b0;
        repeat (3) tick();
        check("del_valid", 64'(rd_valid), 64'd0);
        check("del_frames", 64'(frames), 64'd0);
        wr(2'b01, 32'hE000_0000, 2'd0);
        wr(2'b10, 32'hE000_0001, 2'd1);
        drain(10);
        exp_q.push_back(mk(1'b1, 1'b0, 2'd0, 32'hE000_0000));
        exp_q.push_back(mk(1'b0, 1'b1, 2'd1, 32'hE000_0001));
        compare("del_next");

        // ---- overflow: 20-word frame into 16 entries with the reader stalled
        for (int i = 0; i < 20; i++) begin
            info = (i == 0) ? 2'b01 : ((i == 19) ? 2'b10 : 2'b00);
            wr(info, 32'hF000_0000 + 32'(i), (i == 19) ? 2'd2 : 2'd0);
            if (i == 15) begin
                check("ovf_full16", 64'(full), 64'd1);
                check("ovf_pulse16", 64'(overflow), 64'd0);
            end
            if (i == 16) begin
                check("ovf_pulse17", 64'(overflow), 64'd1);
                check("ovf_drop17", 64'(drop_cnt), 64'd1);
                check("ovf_full17", 64'(full), 64'd0);
            end
            if (i == 17) check("ovf_pulse18", 64'(overflow), 64'd0);
        end
        tick();
        check("ovf_frames", 64'(frames), 64'd0);
        check("ovf_valid", 64'(rd_valid), 64'd0);
        check("ovf_drop_end", 64'(drop_cnt), 64'd1);
        wr(2'b01, 32'h6000_0000, 2'd0);
        wr(2'b00, 32'h6000_0001, 2'd0);
        wr(2'b00, 32'h6000_0002, 2'd0);
        wr(2'b10, 32'h6000_0003, 2'd1);
        check("ovf_next_frames", 64'(frames), 64'd1);
        drain(12);
        exp_q.push_back(mk(1'b1, 1'b0, 2'd0, 32'h6000_0000));
        exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 32'h6000_0001));
        exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 32'h6000_0002));
        exp_q.push_back(mk(1'b0, 1'b1, 2'd1, 32'h6000_0003));
        compare("ovf_next");

        // ---- restart: a start word in mid-frame discards the first 2 words
        wr(2'b01, 32'h7000_0000, 2'd0);
        wr(2'b00, 32'h7000_0001, 2'd0);
        wr(2'b01, 32'h7100_0000, 2'd0);
        wr(2'b00, 32'h7100_0001, 2'd0);
        wr(2'b10, 32'h7100_0002, 2'd0);
        drain(12);
        exp_q.push_back(mk(1'b1, 1'b0, 2'd0, 32'h7100_0000));
        exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 32'h7100_0001));
        exp_q.push_back(mk(1'b0, 1'b1, 2'd0, 32'h7100_0002));
        compare("restart");

        // ---- two frames read with ready toggling 1,0,1,0
        wr(2'b01, 32'h8000_0000, 2'd0);
        wr(2'b10, 32'h8000_0001, 2'd1);
        wr(2'b01, 32'h8100_0000, 2'd0);
        wr(2'b00, 32'h8100_0001, 2'd0);
        wr(2'b10, 32'h8100_0002, 2'd3);
        check("bp_frames", 64'(frames), 64'd2);
        got_q.delete();
        for (int c = 0; c < 30; c++) begin
            rd_ready = (c % 2 == 0);
            snap = {rd_valid, head()};
            if (rd_valid && rd_ready) got_q.push_back(head());
            tick();
            if (snap[36] && !rd_ready)
                check($sformatf("bp_stall_c%0d", c), 64'({rd_valid, head()}), 64'(snap));
        end
        rd_ready = 1'b0;
        exp_q.push_back(mk(1'b1, 1'b0, 2'd0, 32'h8000_0000));
        exp_q.push_back(mk(1'b0, 1'b1, 2'd1, 32'h8000_0001));
        exp_q.push_back(mk(1'b1, 1'b0, 2'd0, 32'h8100_0000));
        exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 32'h8100_0001));
        exp_q.push_back(mk(1'b0, 1'b1, 2'd3, 32'h8100_0002));
        compare("bp");
        check("bp_frames_done", 64'(frames), 64'd0);

        // ---- asynchronous reset while a word is presented
        wr(2'b01, 32'h9000_0000, 2'd0);
        wr(2'b10, 32'h9000_0001, 2'd0);
        tick();
        tick();
        check("ar_valid_pre", 64'(rd_valid), 64'd1);
        check("ar_drop_pre", 64'(drop_cnt), 64'd1);
        rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(rd_valid), 64'd0);
        check("ar_data", 64'(rd_data), 64'd0);
        check("ar_sof", 64'(rd_sof), 64'd0);
        check("ar_frames", 64'(frames), 64'd0);
        check("ar_drop", 64'(drop_cnt), 64'd0);
        #3;
        rst_n = 1'b1;
        repeat (3) tick();
        check("ar_valid_post", 64'(rd_valid), 64'd0);
        check("ar_frames_post", 64'(frames), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
